// File: rtl/pulse_scheduler.sv
// pulse_scheduler
//   Timed issue queue between the core's pulse-descriptor output and the
//   pulse memory fetch stage. Descriptors (address + absolute start time)
//   are buffered in a FIFO. Each head entry is released through a
//   valid/ready issue register once the timebase reaches its timestamp.
//   Entries that are released after their timestamp are flagged late.
//
//   State table:
//     state | meaning
//     IDLE  | timebase held at 0, FIFO accepts pushes, nothing issues
//     RUN   | timebase counts up (saturating), due head entries issue
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, clear            arm timebase / synchronous flush back to IDLE
//   desc_valid/ready/addr/time   descriptor push interface from the core
//   issue_valid/ready/addr/time/late  issue interface to the fetch stage
//   time_now                current timebase
//   fifo_count              FIFO occupancy
//   running                 state == RUN
//   late_err                sticky late-issue flag
module pulse_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 5,
  parameter int TIME_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [ADDR_W-1:0]        desc_addr,
  input  logic [TIME_W-1:0]        desc_time,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [ADDR_W-1:0]        issue_addr,
  output logic [TIME_W-1:0]        issue_time,
  output logic                     issue_late,
  output logic [TIME_W-1:0]        time_now,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     running,
  output logic                     late_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [TIME_W-1:0] mem_time [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] head_addr;
  logic [TIME_W-1:0] head_time;
  logic              full, empty, push, load;

  // full comes from the registered count, so a pop in the same cycle does
  // not open a slot for a push until the next cycle.
  assign full       = (fifo_count == CNT_W'(DEPTH));
  assign empty      = (fifo_count == '0);
  assign desc_ready = !full;
  assign running    = (state == RUN);
  assign head_addr  = mem_addr[rd_ptr];
  assign head_time  = mem_time[rd_ptr];

  assign push = desc_valid && desc_ready && !clear;
  assign load = (state == RUN) && !empty && (head_time <= time_now) &&
                (!issue_valid || issue_ready) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)                       state_nxt = IDLE;
    else if (state == IDLE && start) state_nxt = RUN;
  end

  // Timebase: held at 0 outside RUN, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  time_now <= '0;
    else if (clear || state != RUN)              time_now <= '0;
    else if (time_now != {TIME_W{1'b1}})         time_now <= time_now + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= desc_addr;
      mem_time[wr_ptr] <= desc_time;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue register; "late" compares against the timebase of the load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      issue_time  <= '0;
      issue_late  <= 1'b0;
      late_err    <= 1'b0;
    end else if (clear) begin
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      issue_time  <= '0;
      issue_late  <= 1'b0;
      late_err    <= 1'b0;
    end else if (load) begin
      issue_valid <= 1'b1;
      issue_addr  <= head_addr;
      issue_time  <= head_time;
      issue_late  <= (head_time < time_now);
      if (head_time < time_now) late_err <= 1'b1;
    end else if (issue_valid && issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
module tb_pulse_scheduler;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 5;
  localparam int TIME_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, clear;
  logic              desc_valid, desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [TIME_W-1:0] desc_time;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_addr;
  logic [TIME_W-1:0] issue_time;
  logic              issue_late;
  logic [TIME_W-1:0] time_now;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              running, late_err;

  int n_cmp = 0;
  int n_err = 0;

  pulse_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_time(desc_time),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_addr(issue_addr), .issue_time(issue_time), .issue_late(issue_late),
    .time_now(time_now), .fifo_count(fifo_count),
    .running(running), .late_err(late_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int a, input int t);
    desc_valid = 1'b1;
    desc_addr  = ADDR_W'(a);
    desc_time  = TIME_W'(t);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; clear = 0; desc_valid = 0; desc_addr = '0;
    desc_time = '0; issue_ready = 1'b1;
    #12;
    n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    n_cmp++; if (desc_ready !== 1'b1) begin n_err++; $display("FAIL reset_desc_ready got %b want 1", desc_ready); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (fifo_count !== 0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if (time_now !== 0) begin n_err++; $display("FAIL reset_time got %0d want 0", time_now); end
    n_cmp++; if (running !== 1'b0 || late_err !== 1'b0 || issue_late !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got run=%b lerr=%b late=%b want 0", running, late_err, issue_late); end
    n_cmp++; if (issue_addr !== 0 || issue_time !== 0) begin
      n_err++; $display("FAIL reset_issue_fields got a=%0d t=%0d want 0", issue_addr, issue_time); end
  endtask

  task automatic test_idle_push();
    push_one(3, 10);
    n_cmp++; if (fifo_count !== 1) begin n_err++; $display("FAIL idle_push_count got %0d want 1", fifo_count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (issue_valid !== 1'b0 || time_now !== 0) begin
        n_err++; $display("FAIL idle_no_issue got v=%b t=%0d want v=0 t=0", issue_valid, time_now); end
    end
  endtask

  task automatic test_basic_issue();
    int exp_a [2] = '{3, 7};
    int exp_t [2] = '{11, 13};
    int k = 0;
    push_one(7, 12);
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (running !== 1'b1 || time_now !== 0) begin
      n_err++; $display("FAIL start_run got run=%b t=%0d want run=1 t=0", running, time_now); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (issue_valid === 1'b1) begin
        if (k < 2) begin
          n_cmp++; if (issue_addr !== exp_a[k] || time_now !== exp_t[k] || issue_late !== 1'b0) begin
            n_err++; $display("FAIL basic_issue%0d got a=%0d t=%0d late=%b want a=%0d t=%0d late=0",
                              k, issue_addr, time_now, issue_late, exp_a[k], exp_t[k]); end
        end
        k++;
      end
    end
    n_cmp++; if (k !== 2) begin n_err++; $display("FAIL basic_issue_count got %0d want 2", k); end
    n_cmp++; if (late_err !== 1'b0) begin n_err++; $display("FAIL basic_late_err got %b want 0", late_err); end
    do_clear();
  endtask

  task automatic test_full();
    desc_valid = 1'b1;
    desc_time  = TIME_W'(100);
    for (int i = 0; i < DEPTH; i++) begin
      desc_addr = ADDR_W'(i);
      tick();
    end
    n_cmp++; if (fifo_count !== DEPTH || desc_ready !== 1'b0) begin
      n_err++; $display("FAIL full_state got cnt=%0d rdy=%b want cnt=8 rdy=0", fifo_count, desc_ready); end
    desc_addr = ADDR_W'(31);
    tick();
    desc_valid = 1'b0;
    n_cmp++; if (fifo_count !== DEPTH) begin n_err++; $display("FAIL full_ninth got %0d want 8", fifo_count); end
    do_clear();
    n_cmp++; if (fifo_count !== 0 || desc_ready !== 1'b1) begin
      n_err++; $display("FAIL full_clear got cnt=%0d rdy=%b want cnt=0 rdy=1", fifo_count, desc_ready); end
  endtask

  task automatic test_stall();
    push_one(1, 5);
    push_one(2, 6);
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && time_now < 20; i++) begin
      if (time_now == 4) issue_ready = 1'b0;
      tick();
      if (time_now >= 6 && time_now <= 20) begin
        n_cmp++; if (issue_valid !== 1'b1 || issue_addr !== 1 || issue_time !== 5 || issue_late !== 1'b0) begin
          n_err++; $display("FAIL stall_hold@%0d got v=%b a=%0d ts=%0d late=%b want v=1 a=1 ts=5 late=0",
                            time_now, issue_valid, issue_addr, issue_time, issue_late); end
      end
    end
    n_cmp++; if (time_now !== 20) begin n_err++; $display("FAIL stall_timeout got t=%0d want 20", time_now); end
    issue_ready = 1'b1;
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_addr !== 2 || issue_late !== 1'b1 || late_err !== 1'b1) begin
      n_err++; $display("FAIL stall_late got v=%b a=%0d late=%b lerr=%b want v=1 a=2 late=1 lerr=1",
                        issue_valid, issue_addr, issue_late, late_err); end
    tick();
    n_cmp++; if (issue_valid !== 1'b0 || late_err !== 1'b1) begin
      n_err++; $display("FAIL stall_drain got v=%b lerr=%b want v=0 lerr=1", issue_valid, late_err); end
  endtask

  task automatic test_late_push();
    for (int i = 0; i < 100 && time_now < 50; i++) tick();
    n_cmp++; if (time_now !== 50) begin n_err++; $display("FAIL late_wait got t=%0d want 50", time_now); end
    push_one(4, 0);
    n_cmp++; if (issue_valid !== 1'b0 || fifo_count !== 1) begin
      n_err++; $display("FAIL late_nobypass got v=%b cnt=%0d want v=0 cnt=1", issue_valid, fifo_count); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_addr !== 4 || issue_time !== 0 || issue_late !== 1'b1 || time_now !== 52) begin
      n_err++; $display("FAIL late_issue got v=%b a=%0d ts=%0d late=%b t=%0d want v=1 a=4 ts=0 late=1 t=52",
                        issue_valid, issue_addr, issue_time, issue_late, time_now); end
  endtask

  task automatic test_clear();
    issue_ready = 1'b0;
    push_one(5, 0);
    push_one(6, 0);
    push_one(7, 0);
    n_cmp++; if (fifo_count !== 3 || issue_valid !== 1'b1 || issue_addr !== 4) begin
      n_err++; $display("FAIL clear_setup got cnt=%0d v=%b a=%0d want cnt=3 v=1 a=4", fifo_count, issue_valid, issue_addr); end
    clear = 1'b1; start = 1'b1; desc_valid = 1'b1; desc_addr = ADDR_W'(9); issue_ready = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0; desc_valid = 1'b0;
    n_cmp++; if (running !== 1'b0 || fifo_count !== 0 || issue_valid !== 1'b0 || time_now !== 0 || late_err !== 1'b0) begin
      n_err++; $display("FAIL clear_result got run=%b cnt=%0d v=%b t=%0d lerr=%b want all 0",
                        running, fifo_count, issue_valid, time_now, late_err); end
    tick();
    n_cmp++; if (running !== 1'b0 || time_now !== 0) begin
      n_err++; $display("FAIL clear_stay_idle got run=%b t=%0d want run=0 t=0", running, time_now); end
  endtask

  task automatic test_back_to_back();
    int exp_t [3] = '{4, 5, 6};
    logic exp_l [3] = '{1'b0, 1'b1, 1'b1};
    int k = 0;
    push_one(1, 3);
    push_one(2, 3);
    push_one(3, 3);
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (issue_valid === 1'b1) begin
        if (k < 3) begin
          n_cmp++; if (issue_addr !== k + 1 || time_now !== exp_t[k] || issue_late !== exp_l[k]) begin
            n_err++; $display("FAIL b2b_issue%0d got a=%0d t=%0d late=%b want a=%0d t=%0d late=%b",
                              k, issue_addr, time_now, issue_late, k + 1, exp_t[k], exp_l[k]); end
        end
        k++;
      end
    end
    n_cmp++; if (k !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", k); end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_idle_push();
    test_basic_issue();
    test_full();
    test_stall();
    test_late_push();
    test_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
